// File: rtl/i2s_tx_master.sv
// Stereo I2S / left-justified transmitter, master mode.
// Divides clk_i down to SCK, drives WS, and shifts AUDIO_DW-bit samples out
// MSB-first inside SLOT_DW-bit slots. A one-frame holding buffer decouples
// the sample source from the frame timing; an empty buffer at frame load
// sends a silent frame and pulses underrun_o.
module i2s_tx_master #(
    parameter int AUDIO_DW = 16,
    parameter int SLOT_DW  = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                mode_i,
    input  logic [AUDIO_DW-1:0] l_data_i,
    input  logic [AUDIO_DW-1:0] r_data_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    output logic                sck_o,
    output logic                ws_o,
    output logic                sd_o,
    output logic                frame_start_o,
    output logic                underrun_o
);

    localparam int BIT_W = $clog2(2 * SLOT_DW);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_DW - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_DW);

    // Holding buffer
    logic                hold_valid;
    logic [AUDIO_DW-1:0] hold_l;
    logic [AUDIO_DW-1:0] hold_r;

    // Active frame
    logic [AUDIO_DW-1:0] act_l;
    logic [AUDIO_DW-1:0] act_r;
    logic                mode_q;

    // Bit timing
    logic                running;
    logic [DIV_W-1:0]    div_cnt;
    logic                sck_q;
    logic [BIT_W-1:0]    bit_cnt;
    logic                dly_q;

    logic                frame_start_q;
    logic                underrun_q;

    // Decoded events
    logic                div_wrap;
    logic                fall_tick;
    logic                start_load;
    logic                frame_load;
    logic                accept;

    // Serial mapping
    logic                in_right;
    logic [BIT_W-1:0]    slot_pos;
    logic [AUDIO_DW-1:0] cur_word;
    logic [AUDIO_DW-1:0] shifted;
    logic                lj_bit;

    // Handshake: a pair transfers on any clk_i edge where data_valid_i and
    // data_ready_o are both high; data_ready_o depends only on the buffer
    // state (never on data_valid_i), and the source must hold data stable
    // while data_valid_i is high and data_ready_o is low.
    assign accept       = data_valid_i && !hold_valid;
    assign data_ready_o = !hold_valid;

    // Event decode; disable (en_i low) overrides every timing event.
    always_comb begin
        div_wrap   = running && en_i && (div_cnt == DIV_LAST);
        fall_tick  = div_wrap && sck_q;
        start_load = en_i && !running;
        frame_load = start_load || (fall_tick && (bit_cnt == BIT_LAST));
    end

    // Select the current slot's word and pick its MSB-first bit; shifting by
    // a slot position past the sample width yields the zero padding.
    always_comb begin
        in_right = (bit_cnt >= SLOT_LEN);
        slot_pos = in_right ? (bit_cnt - SLOT_LEN) : bit_cnt;
        cur_word = in_right ? act_r : act_l;
        shifted  = cur_word << slot_pos;
        lj_bit   = shifted[AUDIO_DW-1];
    end

    assign sck_o         = sck_q;
    assign ws_o          = running && in_right;
    assign sd_o          = running && (mode_q ? lj_bit : dly_q);
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;

    // Holding buffer: a load drains a full buffer; otherwise accept a new pair.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
        end else if (frame_load && hold_valid) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_l     <= l_data_i;
            hold_r     <= r_data_i;
        end
    end

    // Frame load: capture mode and the next pair (or silence) plus status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_l         <= '0;
            act_r         <= '0;
            mode_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_start_q <= frame_load;
            underrun_q    <= frame_load && !hold_valid;
            if (frame_load) begin
                mode_q <= mode_i;
                act_l  <= hold_valid ? hold_l : '0;
                act_r  <= hold_valid ? hold_r : '0;
            end
        end
    end

    // SCK divider, bit counter and one-bit I2S delay; WS/SD change with SCK's fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running <= 1'b0;
            div_cnt <= '0;
            sck_q   <= 1'b0;
            bit_cnt <= '0;
            dly_q   <= 1'b0;
        end else if (!en_i) begin
            running <= 1'b0;
            div_cnt <= '0;
            sck_q   <= 1'b0;
            bit_cnt <= '0;
            dly_q   <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
            div_cnt <= '0;
            sck_q   <= 1'b0;
            bit_cnt <= '0;
            dly_q   <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                sck_q   <= !sck_q;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_tick) begin
                dly_q   <= lj_bit;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
Parametrised stereo I2S/left-justified transmitter in master mode.
- Generates SCK and WS from the system clock and serialises AUDIO_DW-bit stereo samples MSB-first into SLOT_DW-bit slots.
- Takes samples through a valid/ready handshake with a one-frame holding buffer, and flags underruns.
- Sits between the audio sample generator and the chip output pins.

Parameters:
AUDIO_DW, 16, sample width per channel (>=2)
SLOT_DW, 32, bits per WS half-frame (>=AUDIO_DW); unused trailing bits are sent as 0
CLK_DIV, 4, clk_i cycles per SCK half-period (>=1); SCK period = 2*CLK_DIV clk_i cycles

Ports:
clk_i  in  1  system clock; all state changes on its rising edge
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  transmit enable
mode_i  in  1  0 = I2S (1-bit data delay after WS edge), 1 = left-justified; sampled at frame load only
l_data_i  in  AUDIO_DW  left sample
r_data_i  in  AUDIO_DW  right sample
data_valid_i  in  1  stereo pair valid
data_ready_o  out  1  holding buffer empty, pair can be accepted
sck_o  out  1  serial bit clock
ws_o  out  1  word select, 0 = left slot, 1 = right slot
sd_o  out  1  serial data
frame_start_o  out  1  one-cycle pulse at each frame load
underrun_o  out  1  one-cycle pulse when a frame load finds the holding buffer empty

Behaviour:
Reset (async, rst_ni=0):
- sck_o, ws_o, sd_o, frame_start_o, underrun_o = 0; data_ready_o = 1.
- Holding buffer empty; active frame register = 0; all counters = 0; running = 0.

Handshake:
- data_ready_o = !hold_valid.
- Accept when data_valid_i & data_ready_o: store {l,r} in the holding buffer, set hold_valid. data_ready_o falls the next cycle.
- Accepting data is independent of en_i.

Clock divider (running=1):
- div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and sck_o toggles.
- The first toggle after start is rising.
- Fall tick = toggle cycle with sck_o==1.

Bit counter:
- bit_cnt counts 0..2*SLOT_DW-1 and advances by 1 on each fall tick, wrapping to 0.
- ws_o, sd_o and bit_cnt all update in the same clk_i edge as sck_o's fall, so data is stable across the SCK rising edge.

Frame load event:
- Occurs on either (en_i & !running), which also sets running, or a fall tick where bit_cnt wraps to 0.
- On load: latch mode_i. If hold_valid, move the buffer into the active frame and clear hold_valid. Otherwise load zeros into the active frame and pulse underrun_o.
- frame_start_o pulses on every load.
- A handshake accepted in the same cycle as an underrun load goes to the holding buffer; it does not bypass. The underrun still fires.
- If the buffer is full at load, it is emptied at load, so data_ready_o rises the next cycle.

Serial mapping, with b = bit_cnt mod SLOT_DW and ch = bit_cnt >= SLOT_DW:
- ws_o = ch in both modes.
- LJ bit = active[ch][AUDIO_DW-1-b] if b<AUDIO_DW, else 0.
- Mode 1: sd_o = LJ bit.
- Mode 0: sd_o = the LJ bit of the previous SCK period, via a delay flop updated on fall ticks. The last right-slot bit therefore appears in bit_cnt=0 of the next frame.
- The delay flop is 0 after reset and after disable.

Disable:
- en_i sampled low clears running at the next clk_i edge, regardless of position in the frame.
- It also forces sck_o, ws_o, sd_o, div_cnt, bit_cnt and the delay flop to 0.
- The holding buffer is retained; the partial frame is lost.
- Re-enable starts a fresh frame at the first frame-load rule.

Mode changes mid-frame have no effect until the next load.
Reset mid-operation behaves as at power-up, and the holding buffer contents are discarded.

Test Plan:
1. Reset, AUDIO_DW=8, SLOT_DW=8, CLK_DIV=2: hold rst_ni=0 with random inputs -> sck_o=ws_o=sd_o=frame_start_o=underrun_o=0, data_ready_o=1; release -> all stay 0 while en_i=0.
2. LJ mode: send L=0xA5, R=0x3C, then en_i=1 -> SCK period 4 clk_i; first SCK rise 2 cycles after enable; sd_o per SCK = 1,0,1,0,0,1,0,1 with ws_o=0, then 0,0,1,1,1,1,0,0 with ws_o=1; frame_start_o single pulse.
3. I2S mode, same data, followed by L=0xFF, R=0x00 -> first frame sd_o = 0,1,0,1,0,0,1,0 | 1,0,0,1,1,1,1,0; the next frame begins with 0 (last R bit), then 1×7.
4. Underrun: supply one pair only -> second frame load pulses underrun_o; all 16 bits of sd_o = 0 (LJ); a pair supplied mid-frame is transmitted the following frame with no underrun.
5. Backpressure and padding, AUDIO_DW=8, SLOT_DW=16: keep data_valid_i=1 -> data_ready_o low from acceptance until the cycle after each load; each slot = 8 data bits + 8 zeros; ws_o toggles every 16 SCK.
6. Mid-frame disruption: drop en_i at bit_cnt=5 -> outputs 0 the next cycle, buffered pair retained and sent first after re-enable; separately assert rst_ni mid-frame -> immediate zero outputs and data_ready_o=1.
